bus_cycle_scheduler: RTL
========================

# bus_cycle_scheduler

Divides the 64 MHz system clock into 1 MHz PET CPU bus cycles and time-multiplexes the shared 17-bit RAM between the 6502 and the Wishbone requester (the SPI bridge). It drives phi2, CPU bus-enable and RAM-ownership/strobe timing. It grants fixed Wishbone slots during phi2-low, and an extra slot when the CPU is halted. It carries no address or data; the RAM mux downstream selects addresses using `ram_owner_o`.

## Interface
- `CYCLES_PER_CPU`, 64: system clocks per CPU cycle (SYS_CLOCK_MHZ / 1 MHz); power of two.
- `RAM_ACCESS_CYCLES`, 5: RAM access length, ns_to_cycles(70).
- `SLOT_A_START`, 2: counter value at which Wishbone slot A is evaluated.
- `SLOT_B_START`, 16: counter value for slot B.
- `SLOT_C_START`, 34: counter value for slot C (CPU-halted cycles only).
- `CPU_STROBE_CYCLE`, 40: counter value of the CPU RAM strobe.
- `CPU_LATCH_CYCLE`, 62: counter value of the CPU data latch strobe.
- `clk_i  in  1  system clock, 64 MHz`
- `reset_i  in  1  synchronous, active-high reset`
- `cpu_stop_i  in  1  request to halt CPU; sampled at the last counter value`
- `wb_req_i  in  1  Wishbone access request (level; held until wb_ack_o)`
- `wb_ack_o  out  1  one-cycle pulse: Wishbone access complete`
- `cpu_phi2_o  out  1  CPU phi2 clock`
- `cpu_be_o  out  1  CPU bus enable (1 = CPU cycle running)`
- `ram_owner_o  out  1  0 = CPU owns RAM, 1 = Wishbone`
- `ram_strobe_o  out  1  one-cycle RAM access start strobe (either owner)`
- `cpu_latch_o  out  1  one-cycle pulse: latch CPU read data`
- `cycle_o  out  $clog2(CYCLES_PER_CPU)  current counter value`

Clock is `clk_i`. Reset is `reset_i`, synchronous and active-high.

## Operation
- Free-running counter 0..CYCLES_PER_CPU-1. It wraps to 0 and is exposed on `cycle_o`.
- Phi2-low half: counter 0..31. Phi2-high half: counter 32..63.
- CPU-run flag:
  - Registered from `~cpu_stop_i` at counter 63. It takes effect at counter 0.
  - When run = 1: `cpu_phi2_o` = 1 for counter 32..63, and `cpu_be_o` = 1 for the whole cycle.
  - When run = 0: `cpu_phi2_o` stays 0 and `cpu_be_o` = 0 for the whole 64-cycle period.
- Wishbone slot FSM states: IDLE → ACCESS → ACK → IDLE.
  - Slot start S is one of SLOT_A_START, SLOT_B_START, or SLOT_C_START. Slot C applies only when run = 0.
  - At counter S in IDLE: if `wb_req_i` = 1, go to ACCESS; otherwise stay IDLE, and the slot is lost.
  - ACCESS: `ram_owner_o` = 1 for counter S+1 .. S+RAM_ACCESS_CYCLES+2.
  - `ram_strobe_o` pulses at S+1.
  - `wb_ack_o` pulses at S+RAM_ACCESS_CYCLES+2 (ACK state); the FSM returns to IDLE on the next clock.
  - `ram_owner_o` returns to 0 at S+RAM_ACCESS_CYCLES+3.
- CPU access, run = 1 only:
  - `ram_strobe_o` pulses at CPU_STROBE_CYCLE.
  - `cpu_latch_o` pulses at CPU_LATCH_CYCLE.
  - `ram_owner_o` = 0 throughout the CPU access.
- Request sampling:
  - `wb_req_i` is sampled only at a slot start. Changes between slot starts are ignored.
  - The requester deasserts `wb_req_i` the cycle after `wb_ack_o`. If it is still high at the next slot start, that is a new access.
- Maximum Wishbone throughput: 2 accesses per CPU cycle while running, 3 while halted.
- Width rule: counter compare constants are truncated to the counter width.
- Elaboration-time checks on parameter legality (`$error`):
  - SLOT_A_START + RAM_ACCESS_CYCLES + 2 < SLOT_B_START.
  - SLOT_B_START + RAM_ACCESS_CYCLES + 2 < 32.
  - SLOT_C_START ≥ 32, and SLOT_C_START + RAM_ACCESS_CYCLES + 2 < CPU_LATCH_CYCLE.

## Timing
- Reset values, all outputs: counter = 0, run = 0, FSM = IDLE, and every output = 0.
- After reset is released:
  - Counter counts from 0. The first period is halted (run = 0).
  - Slot C is active in that first period.
  - The first CPU cycle starts at the following counter 0, if `cpu_stop_i` = 0.
- Reset asserted mid-access:
  - All outputs are 0 on the next clock and no `wb_ack_o` is issued.
  - The requester keeps `wb_req_i` asserted and is served at the first slot after reset.
- Slot timing with default parameters:
  - Slot A: owner = 1 at counters 3..9, strobe at 3, ack at 9.
  - Slot B: owner 17..23, strobe 17, ack 23.
  - Slot C: owner 35..41, strobe 35, ack 41.
- `cpu_stop_i` toggling anywhere except counter 63 has no effect until the next counter 63. Phi2 is never truncated mid-cycle.
- Latency from `wb_req_i` to `wb_ack_o`:
  - Minimum RAM_ACCESS_CYCLES+2 = 7 clocks, when the request is present at the slot start.
  - Worst case while running: 7 + 50 clocks (request arrives just after SLOT_B_START, waits for the next SLOT_A_START).

## Test plan
- Reset then free run, `cpu_stop_i` = 0, `wb_req_i` = 0:
  - The first period shows phi2 = 0 and be = 0.
  - Thereafter phi2 = 1 exactly at counters 32..63.
  - `ram_strobe_o` at 40 and `cpu_latch_o` at 62 every period.
  - `ram_owner_o` stays 0.
- `wb_req_i` held high continuously while running:
  - Two acks per period, at counters 9 and 23.
  - Owner = 1 at 3..9 and 17..23, and never during 32..63.
- `wb_req_i` raised at counter 17 → the slot-B start (16) is missed, so the access is granted at the next SLOT_A_START (counter 2) with ack at counter 9; no strobe is issued at counter 17.
- `cpu_stop_i` = 1 sampled at counter 63 with `wb_req_i` high:
  - Next period: phi2 = 0, be = 0, no CPU strobe or latch.
  - Acks at 9, 23, and 41.
  - Release `cpu_stop_i` → CPU resumes at the next period boundary.
- Reset asserted at counter 5 during a slot-A access:
  - Outputs are 0 next clock and no ack is issued.
  - With the request still held, the first post-reset slot grants the access and acks at counter 9.

Source files
------------

// File: rtl/bus_cycle_scheduler.sv
// bus_cycle_scheduler
// Splits the 64 MHz system clock into 1 MHz PET CPU bus cycles and time-shares the RAM
// between the 6502 and a Wishbone requester. Wishbone gets fixed slots while phi2 is low
// (A and B), plus slot C in the phi2-high half when the CPU is halted.
//
// Ports:
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   cpu_stop_i    halt request, sampled at the last counter value of each CPU cycle
//   wb_req_i      Wishbone request level, sampled only at slot starts
//   wb_ack_o      one-cycle pulse: Wishbone access complete
//   cpu_phi2_o    CPU phi2 clock
//   cpu_be_o      CPU bus enable (1 = CPU cycle running)
//   ram_owner_o   0 = CPU owns RAM, 1 = Wishbone
//   ram_strobe_o  one-cycle RAM access start strobe (either owner)
//   cpu_latch_o   one-cycle pulse: latch CPU read data
//   cycle_o       current position within the CPU cycle
module bus_cycle_scheduler #(
    parameter int unsigned CYCLES_PER_CPU    = 64,
    parameter int unsigned RAM_ACCESS_CYCLES = 5,
    parameter int unsigned SLOT_A_START      = 2,
    parameter int unsigned SLOT_B_START      = 16,
    parameter int unsigned SLOT_C_START      = 34,
    parameter int unsigned CPU_STROBE_CYCLE  = 40,
    parameter int unsigned CPU_LATCH_CYCLE   = 62
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              cpu_stop_i,
    input  logic                              wb_req_i,
    output logic                              wb_ack_o,
    output logic                              cpu_phi2_o,
    output logic                              cpu_be_o,
    output logic                              ram_owner_o,
    output logic                              ram_strobe_o,
    output logic                              cpu_latch_o,
    output logic [$clog2(CYCLES_PER_CPU)-1:0] cycle_o
);

    localparam int unsigned CntW = $clog2(CYCLES_PER_CPU);
    localparam int unsigned AccW = $clog2(RAM_ACCESS_CYCLES + 2);

    // Compare constants are truncated to the counter width.
    localparam logic [CntW-1:0] CntLast   = CntW'(CYCLES_PER_CPU - 1);
    localparam logic [CntW-1:0] CntHalf   = CntW'(CYCLES_PER_CPU / 2);
    localparam logic [CntW-1:0] SlotA     = CntW'(SLOT_A_START);
    localparam logic [CntW-1:0] SlotB     = CntW'(SLOT_B_START);
    localparam logic [CntW-1:0] SlotC     = CntW'(SLOT_C_START);
    localparam logic [CntW-1:0] CpuStrobe = CntW'(CPU_STROBE_CYCLE);
    localparam logic [CntW-1:0] CpuLatch  = CntW'(CPU_LATCH_CYCLE);
    localparam logic [AccW-1:0] AccLast   = AccW'(RAM_ACCESS_CYCLES);

    // Parameter legality
    if ((CYCLES_PER_CPU & (CYCLES_PER_CPU - 1)) != 0) begin : g_chk_pow2
        $error("CYCLES_PER_CPU must be a power of two");
    end
    if (SLOT_A_START + RAM_ACCESS_CYCLES + 2 >= SLOT_B_START) begin : g_chk_slot_a
        $error("slot A access overlaps slot B start");
    end
    if (SLOT_B_START + RAM_ACCESS_CYCLES + 2 >= CYCLES_PER_CPU / 2) begin : g_chk_slot_b
        $error("slot B access runs into the phi2-high half");
    end
    if (SLOT_C_START < CYCLES_PER_CPU / 2) begin : g_chk_slot_c_lo
        $error("slot C must start in the phi2-high half");
    end
    if (SLOT_C_START + RAM_ACCESS_CYCLES + 2 >= CPU_LATCH_CYCLE) begin : g_chk_slot_c_hi
        $error("slot C access runs into the CPU latch cycle");
    end

    typedef enum logic [1:0] {StIdle, StAccess, StAck} wb_state_e;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;
    wb_state_e       state_q, state_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic            slot_start;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            run_q   <= 1'b0;
            state_q <= StIdle;
            acc_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Counter wraps naturally because CYCLES_PER_CPU is a power of two.
    assign cnt_d = cnt_q + CntW'(1);
    // Run flag only changes at the period boundary, so phi2 is never truncated.
    assign run_d = (cnt_q == CntLast) ? ~cpu_stop_i : run_q;

    // Slot C is only offered while the CPU is halted; its window overlaps the CPU access.
    assign slot_start = (cnt_q == SlotA) || (cnt_q == SlotB) || (!run_q && (cnt_q == SlotC));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        unique case (state_q)
            StIdle: begin
                if (slot_start && wb_req_i) begin
                    state_d = StAccess;
                    acc_d   = '0;
                end
            end
            StAccess: begin
                // acc_q counts RAM_ACCESS_CYCLES+1 clocks of ownership before the ack clock.
                if (acc_q == AccLast) begin
                    state_d = StAck;
                end else begin
                    acc_d = acc_q + AccW'(1);
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        wb_ack_o     = 1'b0;
        cpu_phi2_o   = 1'b0;
        cpu_be_o     = 1'b0;
        ram_owner_o  = 1'b0;
        ram_strobe_o = 1'b0;
        cpu_latch_o  = 1'b0;

        cpu_be_o     = run_q;
        cpu_phi2_o   = run_q && (cnt_q >= CntHalf);
        cpu_latch_o  = run_q && (cnt_q == CpuLatch);
        ram_owner_o  = (state_q != StIdle);
        wb_ack_o     = (state_q == StAck);
        ram_strobe_o = ((state_q == StAccess) && (acc_q == '0))
                     || (run_q && (cnt_q == CpuStrobe));
    end

    assign cycle_o = cnt_q;

endmodule
